// File: rtl/video_pkg.sv
// Shared definitions for the video copper: command word layout, opcodes,
// sequencer states and the video register index map.
package video_pkg;

  localparam int CMD_W       = 16;
  localparam int CMD_OP_HI   = 15;
  localparam int CMD_OP_LO   = 14;
  localparam int CMD_REG_HI  = 14;
  localparam int CMD_REG_LO  = 8;
  localparam int CMD_DAT_HI  = 7;
  localparam int CMD_DAT_LO  = 0;
  localparam int CMD_LINE_HI = 8;
  localparam int CMD_LINE_LO = 0;

  typedef enum logic [1:0] {
    OP_WRITE      = 2'b00,
    OP_WAIT_LINE  = 2'b10,
    OP_WAIT_FRAME = 2'b11
  } cop_op_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE      = 2'd1,
    ST_WAIT_LINE  = 2'd2,
    ST_WAIT_FRAME = 2'd3
  } cop_state_t;

  localparam int NUM_VREGS = 16;

  localparam logic [6:0] VCONF    = 7'h00;
  localparam logic [6:0] VPAGE    = 7'h01;
  localparam logic [6:0] GXOFFSL  = 7'h02;
  localparam logic [6:0] GXOFFSH  = 7'h03;
  localparam logic [6:0] GYOFFSL  = 7'h04;
  localparam logic [6:0] GYOFFSH  = 7'h05;
  localparam logic [6:0] TMPAGE   = 7'h06;
  localparam logic [6:0] T0XOFFSL = 7'h07;
  localparam logic [6:0] T0XOFFSH = 7'h08;
  localparam logic [6:0] T0YOFFSL = 7'h09;
  localparam logic [6:0] T0YOFFSH = 7'h0A;
  localparam logic [6:0] T1XOFFSL = 7'h0B;
  localparam logic [6:0] T1XOFFSH = 7'h0C;
  localparam logic [6:0] T1YOFFSL = 7'h0D;
  localparam logic [6:0] T1YOFFSH = 7'h0E;
  localparam logic [6:0] BORDER   = 7'h0F;

  // Bit 15 clear means WRITE regardless of bit 14 (it is part of the index).
  function automatic cop_op_t cmd_op(input logic [1:0] op_bits);
    if (!op_bits[1])     return OP_WRITE;
    else if (!op_bits[0]) return OP_WAIT_LINE;
    else                 return OP_WAIT_FRAME;
  endfunction

endpackage

// File: rtl/vreg_decode.sv
// Turns the registered video write bus into one write strobe per video register.
module vreg_decode
  import video_pkg::*;
(
  input  logic                 i_wr,
  input  logic [6:0]           i_a,
  output logic [NUM_VREGS-1:0] o_strb
);

  localparam logic [6:0] VREG_IDX [NUM_VREGS] = '{
    VCONF, VPAGE, GXOFFSL, GXOFFSH, GYOFFSL, GYOFFSH, TMPAGE, T0XOFFSL,
    T0XOFFSH, T0YOFFSL, T0YOFFSH, T1XOFFSL, T1XOFFSH, T1YOFFSL, T1YOFFSH, BORDER
  };

  for (genvar g = 0; g < NUM_VREGS; g++) begin : g_strb
    assign o_strb[g] = i_wr && (i_a == VREG_IDX[g]);
  end

endmodule

// File: rtl/video_copper.sv
// Line-synchronised command sequencer for the video registers, merged with
// direct CPU writes onto a single registered write bus.
module video_copper
  import video_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int NLINES     = 320
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 cpu_wr,
  input  logic [6:0]           cpu_a,
  input  logic [7:0]           cpu_d,
  input  logic                 cop_push,
  input  logic [CMD_W-1:0]     cop_cmd,
  input  logic                 cop_flush,
  input  logic                 cop_en,
  input  logic                 line_start_s,
  input  logic                 int_start,
  input  logic [8:0]           vcnt,
  output logic                 vreg_wr,
  output logic [6:0]           vreg_a,
  output logic [7:0]           vreg_d,
  output logic                 vreg_src,
  output logic [NUM_VREGS-1:0] vreg_strb,
  output logic                 cop_empty,
  output logic                 cop_full,
  output logic                 cop_busy,
  output logic                 cop_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [8:0] LAST_LINE = 9'(NLINES - 1);

  logic [CMD_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  cop_state_t       r_state;
  cop_state_t       w_state_nxt;
  logic [14:0]      r_cmd;
  logic             r_vreg_wr;
  logic [6:0]       r_vreg_a;
  logic [7:0]       r_vreg_d;
  logic             r_vreg_src;

  logic             w_empty;
  logic             w_full;
  logic [CMD_W-1:0] w_head;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic [8:0]       w_target;
  logic             w_line_hit;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_head   = r_mem[r_rptr];
  // A slot freed by this cycle's pop can take this cycle's push, even when full.
  assign w_push   = cop_push && !cop_flush && (!w_full || w_pop);
  assign w_target = r_cmd[CMD_LINE_HI:CMD_LINE_LO];
  // Targets beyond the last visible line are never matched; only int_start frees them.
  assign w_line_hit = line_start_s && (vcnt == w_target) && (w_target <= LAST_LINE);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cop_en && !w_empty && !cop_flush) begin
          w_pop = 1'b1;
          case (cmd_op(w_head[CMD_OP_HI:CMD_OP_LO]))
            OP_WRITE:     w_state_nxt = ST_WRITE;
            OP_WAIT_LINE: w_state_nxt = ST_WAIT_LINE;
            default:      w_state_nxt = ST_WAIT_FRAME;
          endcase
        end
      end
      ST_WRITE: begin
        if (!cpu_wr && !cop_flush) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_LINE: begin
        if (w_line_hit || int_start) w_state_nxt = ST_IDLE;
      end
      ST_WAIT_FRAME: begin
        if (int_start) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (cop_flush) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (cop_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (cop_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= cop_cmd;
  end

  always_ff @(posedge clk) begin
    if (w_pop) r_cmd <= w_head[14:0];
  end

  // CPU always owns the bus; a copper write waits in ST_WRITE until the bus is free.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_vreg_wr  <= 1'b0;
      r_vreg_a   <= '0;
      r_vreg_d   <= '0;
      r_vreg_src <= 1'b0;
    end else if (cpu_wr) begin
      r_vreg_wr  <= 1'b1;
      r_vreg_a   <= cpu_a;
      r_vreg_d   <= cpu_d;
      r_vreg_src <= 1'b0;
    end else if (w_issue) begin
      r_vreg_wr  <= 1'b1;
      r_vreg_a   <= r_cmd[CMD_REG_HI:CMD_REG_LO];
      r_vreg_d   <= r_cmd[CMD_DAT_HI:CMD_DAT_LO];
      r_vreg_src <= 1'b1;
    end else begin
      r_vreg_wr  <= 1'b0;
      r_vreg_src <= 1'b0;
    end
  end

  vreg_decode u_vreg_decode (
    .i_wr   (r_vreg_wr),
    .i_a    (r_vreg_a),
    .o_strb (vreg_strb)
  );

  assign vreg_wr   = r_vreg_wr;
  assign vreg_a    = r_vreg_a;
  assign vreg_d    = r_vreg_d;
  assign vreg_src  = r_vreg_src;
  assign cop_empty = w_empty;
  assign cop_full  = w_full;
  assign cop_busy  = (r_state != ST_IDLE);
  assign cop_ovf   = r_ovf;

endmodule
